// File: rtl/chunked_adder_acc.sv
// Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock, with a running accumulator.
// Optional signed saturation of the result is enabled by defining CHUNKED_ADDER_SAT_EN.
module chunked_adder_acc #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / CHUNK;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] part;
    logic [WIDTH-1:0] accum;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK:0]   chunk_res;
    logic [WIDTH-1:0] next_part;
    logic [WIDTH-1:0] res_sum;
    logic             last;
    logic             msb_cin;
    logic             res_cout;
    logic             res_ovf;

    always_comb begin
        chunk_a   = CHUNK'(op_a >> (int'(cnt) * CHUNK));
        chunk_b   = CHUNK'(op_b >> (int'(cnt) * CHUNK));
        chunk_res = {1'b0, chunk_a} + {1'b0, chunk_b} + (CHUNK+1)'(carry);
        next_part = part;
        next_part[int'(cnt)*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
        last      = (cnt == CW'(STEPS - 1));
        // The MSB sum bit is a^b^cin, so the carry into the MSB falls out of it directly.
        msb_cin   = op_a[WIDTH-1] ^ op_b[WIDTH-1] ^ next_part[WIDTH-1];
        res_cout  = chunk_res[CHUNK];
        res_ovf   = msb_cin ^ res_cout;
        res_sum   = next_part;
`ifdef CHUNKED_ADDER_SAT_EN
        // Overflow only happens when both operands share a sign; that sign picks the limit.
        if (res_ovf) begin
            res_sum = op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            accum     <= '0;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            part      <= '0;
            carry     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_a     <= acc ? accum : a;
                        op_b     <= sub ? ~b : b;
                        carry    <= sub;
                        cnt      <= '0;
                        part     <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    part  <= next_part;
                    carry <= chunk_res[CHUNK];
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        sum       <= res_sum;
                        cout      <= res_cout;
                        ovf       <= res_ovf;
                        accum     <= res_sum;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_adder_acc.sv
// Directed, table-driven bench for chunked_adder_acc (default 16/4 build).
// Expectations follow CHUNKED_ADDER_SAT_EN when the bench is compiled with it.
module tb_chunked_adder_acc;

    localparam int WIDTH = 16;
    localparam int STEPS = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             acc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks   = 0;
    int failures = 0;

    chunked_adder_acc #(.WIDTH(WIDTH), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .acc(acc),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        acc;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for in_ready, presents one operation and returns right after the accepting edge.
    task automatic start_op(input logic [15:0] va, input logic [15:0] vb,
                            input logic vs, input logic vacc);
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_timeout: in_ready never rose");
        end
        a = va; b = vb; sub = vs; acc = vacc; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Waits for the result, checks latency and outputs, then completes the handshake.
    task automatic finish_op(input string name, input logic [15:0] es,
                             input logic ec, input logic eo);
        int lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (out_valid !== 1'b1 && lat < 20);
        check({name, "_latency"}, lat, STEPS);
        check({name, "_sum"}, sum, es);
        check({name, "_cout"}, cout, ec);
        check({name, "_ovf"}, ovf, eo);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
`ifdef CHUNKED_ADDER_SAT_EN
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1};
`else
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
`endif
        vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; acc = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
        check("reset_ovf", ovf, 0);

        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].acc);
            finish_op($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].ovf);
        end

        // Accumulator sequence from a clean reset.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            start_op(16'hDEAD, 16'h0100, 1'b0, 1'b1);
            finish_op($sformatf("acc%0d", i), 16'(i * 256), 1'b0, 1'b0);
        end
        start_op(16'hDEAD, 16'h0300, 1'b1, 1'b1);
        finish_op("acc_sub", 16'h0000, 1'b1, 1'b0);

        // Backpressure: result must hold while a new request waits.
        start_op(16'h1000, 16'h0234, 1'b0, 1'b0);
        begin
            int lat = 0;
            do begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end while (out_valid !== 1'b1 && lat < 20);
            check("hold_latency", lat, STEPS);
        end
        a = 16'h0010; b = 16'h0020; sub = 1'b0; acc = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold_sum%0d", i), sum, 16'h1234);
            check($sformatf("hold_valid%0d", i), out_valid, 1);
            check($sformatf("hold_ready%0d", i), in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("release_in_ready", in_ready, 1);
        check("release_out_valid", out_valid, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("pending_accepted", in_ready, 0);
        finish_op("pending", 16'h0030, 1'b0, 1'b0);

        // Reset landing on the second RUN cycle drops the op and clears the accumulator.
        start_op(16'h4444, 16'h1111, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrun_rst_in_ready", in_ready, 1);
        check("midrun_rst_out_valid", out_valid, 0);
        check("midrun_rst_sum", sum, 0);
        repeat (6) begin
            @(negedge clk);
            check("midrun_rst_no_result", out_valid, 0);
        end
        start_op(16'hBEEF, 16'h0001, 1'b0, 1'b1);
        finish_op("after_rst_acc", 16'h0001, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
